// File: rtl/vx_wb_arbiter_if.sv
// Commit-side and writeback-side signal bundle for vx_wb_arbiter.
// slave = arbiter view, master = execute units / issue slice view.
interface vx_wb_arbiter_if #(
    parameter int NUM_INPUTS = 4,
    parameter int SIMD_WIDTH = 4,
    parameter int XLEN       = 32,
    parameter int UUID_W     = 44,
    parameter int WIS_W      = 2,
    parameter int REG_W      = 6
);
    logic [NUM_INPUTS-1:0]                 in_valid;
    logic [NUM_INPUTS-1:0]                 in_ready;
    logic [NUM_INPUTS*UUID_W-1:0]          in_uuid;
    logic [NUM_INPUTS*WIS_W-1:0]           in_wis;
    logic [NUM_INPUTS*SIMD_WIDTH-1:0]      in_tmask;
    logic [NUM_INPUTS*REG_W-1:0]           in_rd;
    logic [NUM_INPUTS*SIMD_WIDTH*XLEN-1:0] in_data;
    logic [NUM_INPUTS-1:0]                 in_sop;
    logic [NUM_INPUTS-1:0]                 in_eop;

    logic                                  wb_valid;
    logic [UUID_W-1:0]                     wb_uuid;
    logic [WIS_W-1:0]                      wb_wis;
    logic [SIMD_WIDTH-1:0]                 wb_tmask;
    logic [REG_W-1:0]                      wb_rd;
    logic [SIMD_WIDTH*XLEN-1:0]            wb_data;
    logic                                  wb_sop;
    logic                                  wb_eop;

    modport slave (
        input  in_valid, in_uuid, in_wis, in_tmask, in_rd, in_data, in_sop, in_eop,
        output in_ready,
        output wb_valid, wb_uuid, wb_wis, wb_tmask, wb_rd, wb_data, wb_sop, wb_eop
    );

    modport master (
        output in_valid, in_uuid, in_wis, in_tmask, in_rd, in_data, in_sop, in_eop,
        input  in_ready,
        input  wb_valid, wb_uuid, wb_wis, wb_tmask, wb_rd, wb_data, wb_sop, wb_eop
    );
endinterface

// File: rtl/vx_wb_arbiter.sv
// Packet-aware round-robin writeback arbiter: N commit channels onto one ack-free beat register.
// Optional macro WB_ARB_PERF_EN adds the perf_stalls counter output.
module vx_wb_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int SIMD_WIDTH = 4,
    parameter int XLEN       = 32,
    parameter int UUID_W     = 44,
    parameter int WIS_W      = 2,
    parameter int REG_W      = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    vx_wb_arbiter_if.slave        bus
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]           perf_stalls
`endif
);
    localparam int IDX_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int DATA_W = SIMD_WIDTH * XLEN;

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;

    logic [IDX_W-1:0]   rr_idx;
    logic               rr_found;
    int unsigned        cand;
    logic [IDX_W-1:0]   sel_idx;
    logic [NUM_INPUTS-1:0] ready_fsm;
    logic [NUM_INPUTS-1:0] in_ready_w;
    logic               fire;

    logic [UUID_W-1:0]     uuid_arr  [NUM_INPUTS];
    logic [WIS_W-1:0]      wis_arr   [NUM_INPUTS];
    logic [SIMD_WIDTH-1:0] tmask_arr [NUM_INPUTS];
    logic [REG_W-1:0]      rd_arr    [NUM_INPUTS];
    logic [DATA_W-1:0]     data_arr  [NUM_INPUTS];

    logic                  wb_valid_q;
    logic [UUID_W-1:0]     wb_uuid_q;
    logic [WIS_W-1:0]      wb_wis_q;
    logic [SIMD_WIDTH-1:0] wb_tmask_q;
    logic [REG_W-1:0]      wb_rd_q;
    logic [DATA_W-1:0]     wb_data_q;
    logic                  wb_sop_q;
    logic                  wb_eop_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_ch
            assign uuid_arr[gi]  = bus.in_uuid [gi*UUID_W     +: UUID_W];
            assign wis_arr[gi]   = bus.in_wis  [gi*WIS_W      +: WIS_W];
            assign tmask_arr[gi] = bus.in_tmask[gi*SIMD_WIDTH +: SIMD_WIDTH];
            assign rd_arr[gi]    = bus.in_rd   [gi*REG_W      +: REG_W];
            assign data_arr[gi]  = bus.in_data [gi*DATA_W     +: DATA_W];
        end
    endgenerate

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            cand = (int'(last_grant_q) + k) % NUM_INPUTS;
            if (!rr_found && bus.in_valid[cand]) begin
                rr_found = 1'b1;
                rr_idx   = IDX_W'(cand);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_grant_q <= IDX_W'(NUM_INPUTS - 1);
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    // FSM next-state
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    last_grant_d = sel_idx;
                    if (!bus.in_eop[sel_idx]) begin
                        state_d = LOCKED;
                        owner_d = sel_idx;
                    end
                end
            end
            LOCKED: begin
                if (fire && bus.in_eop[sel_idx]) begin
                    state_d      = IDLE;
                    last_grant_d = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: grant vector and beat select
    always_comb begin
        ready_fsm = '0;
        sel_idx   = rr_idx;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (rr_found) ready_fsm[rr_idx] = 1'b1;
                end
                LOCKED: begin
                    sel_idx            = owner_q;
                    ready_fsm[owner_q] = bus.in_valid[owner_q];
                end
                default: ready_fsm = '0;
            endcase
        end
    end

    // A single channel needs no arbitration: it is always accepted outside reset.
    generate
        if (NUM_INPUTS == 1) begin : g_single
            assign in_ready_w = ~reset;
        end else begin : g_multi
            assign in_ready_w = ready_fsm;
        end
    endgenerate

    assign bus.in_ready = in_ready_w;
    assign fire         = |(bus.in_valid & in_ready_w);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_uuid_q  <= '0;
            wb_wis_q   <= '0;
            wb_tmask_q <= '0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_sop_q   <= 1'b0;
            wb_eop_q   <= 1'b0;
        end else begin
            wb_valid_q <= fire;
            if (fire) begin
                wb_uuid_q  <= uuid_arr[sel_idx];
                wb_wis_q   <= wis_arr[sel_idx];
                wb_tmask_q <= tmask_arr[sel_idx];
                wb_rd_q    <= rd_arr[sel_idx];
                wb_data_q  <= data_arr[sel_idx];
                wb_sop_q   <= bus.in_sop[sel_idx];
                wb_eop_q   <= bus.in_eop[sel_idx];
            end
        end
    end

    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_uuid  = wb_uuid_q;
    assign bus.wb_wis   = wb_wis_q;
    assign bus.wb_tmask = wb_tmask_q;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.wb_sop   = wb_sop_q;
    assign bus.wb_eop   = wb_eop_q;

`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_stalls_q;
    logic        stall_any;

    assign stall_any = |(bus.in_valid & ~in_ready_w);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stalls_q <= '0;
        end else if (stall_any && (perf_stalls_q != '1)) begin
            perf_stalls_q <= perf_stalls_q + 32'd1;
        end
    end

    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_vx_wb_arbiter.sv
// Directed self-checking bench for vx_wb_arbiter (default 4-channel configuration).
module tb_vx_wb_arbiter;
    localparam int N    = 4;
    localparam int SW   = 4;
    localparam int XL   = 32;
    localparam int UW   = 44;
    localparam int WW   = 2;
    localparam int RW   = 6;
    localparam int DW   = SW * XL;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    vx_wb_arbiter_if #(.NUM_INPUTS(N), .SIMD_WIDTH(SW), .XLEN(XL),
                       .UUID_W(UW), .WIS_W(WW), .REG_W(RW)) bus ();

`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_stalls;
`endif

    vx_wb_arbiter #(.NUM_INPUTS(N), .SIMD_WIDTH(SW), .XLEN(XL),
                    .UUID_W(UW), .WIS_W(WW), .REG_W(RW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef WB_ARB_PERF_EN
        ,
        .perf_stalls (perf_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.in_valid = '0;
        bus.in_uuid  = '0;
        bus.in_wis   = '0;
        bus.in_tmask = '0;
        bus.in_rd    = '0;
        bus.in_data  = '0;
        bus.in_sop   = '0;
        bus.in_eop   = '0;
    endtask

    task automatic set_ch(input int ch, input logic v, input logic [RW-1:0] rd,
                          input logic [DW-1:0] data, input logic [SW-1:0] tmask,
                          input logic sop, input logic eop);
        bus.in_valid[ch]             = v;
        bus.in_uuid[ch*UW +: UW]     = UW'(ch + 100);
        bus.in_wis[ch*WW +: WW]      = WW'(ch);
        bus.in_tmask[ch*SW +: SW]    = tmask;
        bus.in_rd[ch*RW +: RW]       = rd;
        bus.in_data[ch*DW +: DW]     = data;
        bus.in_sop[ch]               = sop;
        bus.in_eop[ch]               = eop;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        bus.in_valid = 4'b1111;
        #2;
        n_checks++;
        if (bus.in_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ready: got %b want 0000", bus.in_ready);
        end
        step();
        n_checks++;
        if (bus.wb_valid !== 1'b0 || bus.wb_rd !== '0 || bus.wb_data !== '0) begin
            n_fail++; $display("FAIL reset_outputs: valid=%b rd=%0d data=%h want 0", bus.wb_valid, bus.wb_rd, bus.wb_data);
        end
        $display("test_reset: in_ready=%b wb_valid=%b", bus.in_ready, bus.wb_valid);
        clear_inputs();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_single_beat();
        logic [DW-1:0] d;
        d = {32'hD, 32'hC, 32'hB, 32'hA};
        do_reset();
        set_ch(1, 1'b1, 6'd5, d, 4'hF, 1'b1, 1'b1);
        #1;
        n_checks++;
        if (bus.in_ready !== 4'b0010) begin
            n_fail++; $display("FAIL single_ready: got %b want 0010", bus.in_ready);
        end
        step();
        clear_inputs();
        n_checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 6'd5 || bus.wb_data !== d ||
            bus.wb_sop !== 1'b1 || bus.wb_eop !== 1'b1 || bus.wb_uuid !== 44'd101) begin
            n_fail++; $display("FAIL single_beat: valid=%b rd=%0d data=%h sop=%b eop=%b want 1 5 %h 1 1",
                               bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_sop, bus.wb_eop, d);
        end
        $display("test_single_beat: wb_valid=%b rd=%0d data=%h", bus.wb_valid, bus.wb_rd, bus.wb_data);
        step();
        n_checks++;
        if (bus.wb_valid !== 1'b0 || bus.wb_rd !== 6'd5) begin
            n_fail++; $display("FAIL single_drop: valid=%b rd=%0d want 0 5 (held)", bus.wb_valid, bus.wb_rd);
        end
    endtask

    task automatic test_round_robin();
        int exp_order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int c = 0; c < N; c++) set_ch(c, 1'b1, RW'(10 + c), DW'(c), 4'hF, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (bus.in_ready !== 4'(1 << exp_order[i])) begin
                n_fail++; $display("FAIL rr_ready[%0d]: got %b want ch%0d", i, bus.in_ready, exp_order[i]);
            end
            step();
            n_checks++;
            if (bus.wb_valid !== 1'b1 || bus.wb_rd !== RW'(10 + exp_order[i])) begin
                n_fail++; $display("FAIL rr_grant[%0d]: valid=%b rd=%0d want 1 %0d", i, bus.wb_valid, bus.wb_rd, 10 + exp_order[i]);
            end
            $display("test_round_robin: beat %0d from rd=%0d", i, bus.wb_rd);
        end
        clear_inputs();
    endtask

    task automatic test_packet_lock();
        int exp_rd [4] = '{1, 2, 3, 20};
        do_reset();
        // Prime last_grant to 1 so channel 2 has priority over channel 0.
        set_ch(1, 1'b1, 6'd9, '0, 4'hF, 1'b1, 1'b1);
        step();
        clear_inputs();
        set_ch(0, 1'b1, 6'd20, '0, 4'hF, 1'b1, 1'b1);
        for (int b = 0; b < 4; b++) begin
            if (b < 3) set_ch(2, 1'b1, RW'(b + 1), DW'(b), 4'hF, b == 0, b == 2);
            else       set_ch(2, 1'b0, '0, '0, '0, 1'b0, 1'b0);
            #1;
            n_checks++;
            if (bus.in_ready !== ((b < 3) ? 4'b0100 : 4'b0001)) begin
                n_fail++; $display("FAIL lock_ready[%0d]: got %b want %b", b, bus.in_ready, (b < 3) ? 4'b0100 : 4'b0001);
            end
            step();
            n_checks++;
            if (bus.wb_valid !== 1'b1 || bus.wb_rd !== RW'(exp_rd[b])) begin
                n_fail++; $display("FAIL lock_beat[%0d]: valid=%b rd=%0d want 1 %0d", b, bus.wb_valid, bus.wb_rd, exp_rd[b]);
            end
            $display("test_packet_lock: beat %0d rd=%0d", b, bus.wb_rd);
        end
        clear_inputs();
    endtask

    task automatic test_bubble();
        do_reset();
        set_ch(1, 1'b1, 6'd9, '0, 4'hF, 1'b1, 1'b1);
        step();
        clear_inputs();
        set_ch(3, 1'b1, 6'd33, '0, 4'hF, 1'b1, 1'b1);
        set_ch(2, 1'b1, 6'd21, '0, 4'hF, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (bus.in_ready !== 4'b0100) begin
            n_fail++; $display("FAIL bubble_first: got %b want 0100", bus.in_ready);
        end
        step();
        set_ch(2, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (bus.in_ready !== 4'b0000) begin
                n_fail++; $display("FAIL bubble_ready[%0d]: got %b want 0000", i, bus.in_ready);
            end
            step();
            n_checks++;
            if (bus.wb_valid !== 1'b0) begin
                n_fail++; $display("FAIL bubble_valid[%0d]: got %b want 0", i, bus.wb_valid);
            end
            $display("test_bubble: bubble %0d wb_valid=%b", i, bus.wb_valid);
        end
        set_ch(2, 1'b1, 6'd22, '0, 4'hF, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (bus.in_ready !== 4'b0100) begin
            n_fail++; $display("FAIL bubble_resume_ready: got %b want 0100", bus.in_ready);
        end
        step();
        set_ch(2, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        n_checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 6'd22 || bus.wb_eop !== 1'b1) begin
            n_fail++; $display("FAIL bubble_resume: valid=%b rd=%0d eop=%b want 1 22 1", bus.wb_valid, bus.wb_rd, bus.wb_eop);
        end
        #1;
        n_checks++;
        if (bus.in_ready !== 4'b1000) begin
            n_fail++; $display("FAIL bubble_after: got %b want 1000", bus.in_ready);
        end
        $display("test_bubble: resumed rd=%0d then in_ready=%b", bus.wb_rd, bus.in_ready);
        step();
        clear_inputs();
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        set_ch(1, 1'b1, 6'd11, '0, 4'hF, 1'b1, 1'b0);
        step();
        n_checks++;
        if (bus.wb_valid !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pre: wb_valid=%b want 1", bus.wb_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.wb_valid !== 1'b0 || bus.in_ready !== 4'b0000) begin
            n_fail++; $display("FAIL midrst_async: wb_valid=%b in_ready=%b want 0 0000", bus.wb_valid, bus.in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        set_ch(0, 1'b1, 6'd40, '0, 4'hF, 1'b1, 1'b1);
        set_ch(1, 1'b1, 6'd12, '0, 4'hF, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (bus.in_ready !== 4'b0001) begin
            n_fail++; $display("FAIL midrst_ready: got %b want 0001", bus.in_ready);
        end
        step();
        n_checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 6'd40) begin
            n_fail++; $display("FAIL midrst_grant: valid=%b rd=%0d want 1 40", bus.wb_valid, bus.wb_rd);
        end
        $display("test_reset_mid_packet: first grant after release rd=%0d", bus.wb_rd);
        clear_inputs();
        step();
    endtask

    task automatic test_zero_tmask();
        do_reset();
        set_ch(3, 1'b1, 6'd7, {4{32'h5A5A5A5A}}, 4'h0, 1'b1, 1'b1);
        step();
        clear_inputs();
        n_checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_tmask !== 4'h0 || bus.wb_rd !== 6'd7 || bus.wb_wis !== 2'd3) begin
            n_fail++; $display("FAIL zero_tmask: valid=%b tmask=%h rd=%0d wis=%0d want 1 0 7 3",
                               bus.wb_valid, bus.wb_tmask, bus.wb_rd, bus.wb_wis);
        end
        $display("test_zero_tmask: wb_valid=%b tmask=%h", bus.wb_valid, bus.wb_tmask);
        step();
    endtask

`ifdef WB_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        n_checks++;
        if (perf_stalls !== 32'd0) begin
            n_fail++; $display("FAIL perf_reset: got %0d want 0", perf_stalls);
        end
        set_ch(0, 1'b1, 6'd1, '0, 4'hF, 1'b1, 1'b1);
        set_ch(1, 1'b1, 6'd2, '0, 4'hF, 1'b1, 1'b1);
        repeat (4) step();
        clear_inputs();
        step();
        n_checks++;
        if (perf_stalls !== 32'd4) begin
            n_fail++; $display("FAIL perf_stalls: got %0d want 4", perf_stalls);
        end
        $display("test_perf: perf_stalls=%0d", perf_stalls);
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        clear_inputs();
        test_reset();
        test_single_beat();
        test_round_robin();
        test_packet_lock();
        test_bubble();
        test_reset_mid_packet();
        test_zero_tmask();
`ifdef WB_ARB_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/vx_wb_arbiter.md
VX_WB_ARBITER -- requirements
Module: VX_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 4: number of execute-unit commit channels, range 1..8.
REQ-002 SHALL have parameter SIMD_WIDTH, default 4: lanes per writeback beat.
REQ-003 SHALL have parameter XLEN, default 32: bits per lane datum.
REQ-004 SHALL have parameters UUID_W=44, WIS_W=2, REG_W=6: widths of the uuid, warp-in-slice and register index fields.
REQ-005 SHALL have port: clk  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port: in_valid  in  NUM_INPUTS  per-channel commit valid.
REQ-008 SHALL have port: in_ready  out  NUM_INPUTS  per-channel commit accept.
REQ-009 SHALL have ports: in_uuid, in_wis, in_tmask, in_rd, in_data  in  NUM_INPUTS x (UUID_W, WIS_W, SIMD_WIDTH, REG_W, SIMD_WIDTH*XLEN)  packed per-channel beat fields, channel i in slice i.
REQ-010 SHALL have ports: in_sop, in_eop  in  NUM_INPUTS  per-channel start-of-packet and end-of-packet flags.
REQ-011 SHALL have ports: wb_valid, wb_uuid, wb_wis, wb_tmask, wb_rd, wb_data, wb_sop, wb_eop  out  (1, UUID_W, WIS_W, SIMD_WIDTH, REG_W, SIMD_WIDTH*XLEN, 1, 1)  ack-free writeback beat to the issue slice (no ready).

Function
REQ-012 SHALL transfer a beat on channel i when in_valid[i] && in_ready[i]; in_ready SHALL be asserted for at most one channel per cycle.
REQ-013 SHALL register the transferred beat so that wb_* presents it exactly 1 cycle after transfer, wb_valid high for exactly that cycle.
REQ-014 SHALL drive wb_valid low in any cycle following a cycle with no transfer; wb_* data fields hold their last value.
REQ-015 SHALL assert in_ready combinationally from in_valid and arbiter state only; the output register is always free (ack-free sink).
REQ-016 SHALL run a two-state FSM: IDLE (no packet open) and LOCKED (packet open, owner index held).
REQ-017 In IDLE, SHALL grant round-robin: highest priority is (last_grant+1) mod NUM_INPUTS, searching upward with wrap-around.
REQ-018 On an IDLE transfer with in_eop=0, SHALL enter LOCKED with owner = granted channel; with in_eop=1, SHALL stay IDLE.
REQ-019 In LOCKED, SHALL assert in_ready only for owner (when owner valid); other channels SHALL stall even if valid.
REQ-020 In LOCKED, if owner is not valid, SHALL transfer nothing (bubble) and remain LOCKED.
REQ-021 In LOCKED, owner transfer with in_eop=1 SHALL return to IDLE and set last_grant = owner.
REQ-022 SHALL update last_grant on every IDLE grant; single-beat packets thus rotate priority every beat.
REQ-023 SHALL forward in_sop/in_eop unmodified; sop on a non-first beat of an open packet is passed through, not checked.
REQ-024 SHALL forward beats with in_tmask all zero unchanged (wb_valid still asserted).
REQ-025 With NUM_INPUTS=1, SHALL reduce to a single registered pass-through with in_ready[0]=1.

Reset
REQ-026 On reset assertion, SHALL immediately drive wb_valid=0, FSM=IDLE, last_grant=NUM_INPUTS-1 (channel 0 highest priority first), data registers 0.
REQ-027 Reset mid-packet SHALL discard the lock; after release the owner's remaining beats arbitrate as new IDLE requests.
REQ-028 SHALL drive in_ready all-zero while reset is asserted.

Configuration
REQ-029 When WB_ARB_PERF_EN is defined, SHALL add output perf_stalls (out, 32 bits, reset 0) incrementing by 1 each cycle some channel is valid but not ready, saturating at all-ones.
REQ-030 When WB_ARB_PERF_EN is undefined, SHALL omit perf_stalls and its counter logic entirely; function otherwise identical.

Verification
REQ-031 Ch1 single beat (rd=5, data lanes 0xA..0xD, sop=eop=1) at cycle 0 -> wb_valid=1 at cycle 1 with rd=5 and identical data, wb_valid=0 at cycle 2.
REQ-032 After reset, all 4 channels hold single-beat requests -> grants in order 0,1,2,3,0, one per cycle.
REQ-033 Ch2 sends 3-beat packet (eop on beat 3) with ch0 valid throughout -> ch2's beats output contiguously, ch0 granted next cycle after ch2 eop.
REQ-034 Ch2 locked, drops valid 2 cycles mid-packet while ch3 valid -> 2 bubble cycles (wb_valid=0, ch3 in_ready=0), then ch2 resumes.
REQ-035 Reset asserted while ch1 locked -> wb_valid=0 same cycle; after release, ch0 and ch1 valid -> ch0 granted first.
REQ-036 With WB_ARB_PERF_EN: ch0 and ch1 valid for 4 cycles with single beats -> perf_stalls=4.
